comar_gate_vec: RTL

- Parametrised successor to the 2-share COMAR NOR gadget. It holds LANES independent first-order COMAR non-linear gates.
- Each lane computes AND, NAND, OR or NOR, selected by a per-transaction mode. All lanes share one 6-bit fresh-mask word, which is the COMAR mask reuse.
- Adds a valid pipeline, an optional internal mask-hold register and an asynchronous reset.
- Sits in masked S-box/datapath layers wherever several 2-input non-linear gates fire in the same cycle.

---
 rtl/comar_gate_vec.sv | 138 +++++++++++++
 1 files changed

// File: rtl/comar_gate_vec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : comar_gate_vec                                                    |
// | Brief  : LANES first-order 2-share COMAR AND/NAND/OR/NOR gates sharing one |
// |          6-bit fresh-mask word, two register stages, async reset.          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module comar_gate_vec #(
  parameter int LANES    = 4,
  parameter bit OPT      = 1'b0,
  parameter bit MASK_REG = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [1:0]         mode,
  input  logic [2*LANES-1:0] a,
  input  logic [2*LANES-1:0] b,
  input  logic [5:0]         r,
  input  logic               mask_load,
  input  logic [LANES-1:0]   common_out,
  output logic               out_valid,
  output logic [2*LANES-1:0] c
);

  logic [5:0]       m;
  logic [LANES-1:0] a_sh0, a_sh1, b_sh0, b_sh1;

  always_comb begin
    a_sh0 = '0;
    a_sh1 = '0;
    b_sh0 = '0;
    b_sh1 = '0;
    for (int i = 0; i < LANES; i++) begin
      a_sh0[i] = a[2*i];
      a_sh1[i] = a[2*i+1];
      b_sh0[i] = b[2*i];
      b_sh1[i] = b[2*i+1];
    end
  end

  generate
    if (MASK_REG) begin : g_mask_reg
      logic [5:0] mask_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mask_q <= '0;
        end else if (mask_load) begin
          mask_q <= r;
        end
      end
      assign m = mask_q;
    end else begin : g_mask_direct
      logic unused_mask_load;
      assign unused_mask_load = mask_load;
      assign m = r;
    end
  endgenerate

  // Stage 0: refresh share 0 and fold the input inversion into it.
  logic [LANES-1:0] x0_q, y0_q, x1, y1;
  logic [1:0]       mode_s0;
  logic             valid_s0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q     <= '0;
      y0_q     <= '0;
      mode_s0  <= '0;
      valid_s0 <= 1'b0;
    end else begin
      x0_q     <= a_sh0 ^ {LANES{m[0] ^ mode[1]}};
      y0_q     <= b_sh0 ^ {LANES{m[1] ^ mode[1]}};
      mode_s0  <= mode;
      valid_s0 <= in_valid;
    end
  end

  // With OPT=1 share 1 bypasses the refresh, so m[1:0] are not cancelled
  // on that path; callers of the bypass variant keep m[1:0] at zero.
  generate
    if (!OPT) begin : g_share1_reg
      logic [LANES-1:0] x1_q, y1_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x1_q <= '0;
          y1_q <= '0;
        end else begin
          x1_q <= a_sh1 ^ {LANES{m[0]}};
          y1_q <= b_sh1 ^ {LANES{m[1]}};
        end
      end
      assign x1 = x1_q;
      assign y1 = y1_q;
    end else begin : g_share1_bypass
      assign x1 = a_sh1;
      assign y1 = b_sh1;
    end
  endgenerate

  // Stage 1: four masked cross products, each behind its own register.
  logic [LANES-1:0] p00_q, p01_q, p10_q, p11_q;
  logic [1:0]       mode_s1;
  logic             valid_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p00_q    <= '0;
      p01_q    <= '0;
      p10_q    <= '0;
      p11_q    <= '0;
      mode_s1  <= '0;
      valid_s1 <= 1'b0;
    end else begin
      p00_q    <= (x0_q & y0_q) ^ {LANES{m[2]}};
      p01_q    <= (x0_q & y1)   ^ {LANES{m[3]}};
      p10_q    <= (x1   & y0_q) ^ {LANES{m[4]}};
      p11_q    <= (x1   & y1)   ^ {LANES{m[5]}};
      mode_s1  <= mode_s0;
      valid_s1 <= valid_s0;
    end
  end

  always_comb begin
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c[2*i]   = p00_q[i] ^ p01_q[i] ^ p10_q[i] ^ p11_q[i] ^ mode_s1[0];
      c[2*i+1] = common_out[i];
    end
  end

  assign out_valid = valid_s1;

  logic unused_mode_s1;
  assign unused_mode_s1 = mode_s1[1];

endmodule
`default_nettype wire
